// File: rtl/otter_param_reg_file.sv
// -----------------------------------------------------------------------------
// otter_param_reg_file
//   Parametrised OTTER register file with an in-file hazard scoreboard (one
//   busy bit per entry) and a sequential clear engine that zeroes the array
//   after reset or on request.
//
// Ports:
//   i_clk, i_rst_n         clock (rising edge), async active-low reset
//   i_wr_en/addr/data      writeback write port; also clears the busy bit
//   i_rd_addr              packed read addresses, port i = [i*ADDR_W +: ADDR_W]
//   o_rd_data              packed combinational read data
//   o_rd_busy              per-port busy flag of the addressed entry
//   i_issue_en/addr        marks a destination busy at issue
//   i_clr_req              restart the clear engine (array + scoreboard)
//   o_ready                high when the file accepts traffic
//
// Build option:
//   OTTER_RF_BYPASS_EN     when defined, a legal write is forwarded to read
//                          ports addressing the same entry in the same cycle.
// -----------------------------------------------------------------------------
module otter_param_reg_file #(
  parameter int unsigned  DATA_W   = 32,
  parameter int unsigned  DEPTH    = 32,
  parameter int unsigned  NUM_RD   = 2,
  parameter bit           ZERO_REG = 1'b1,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr_en,
  input  logic [ADDR_W-1:0]          i_wr_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
  output logic [NUM_RD-1:0]          o_rd_busy,
  input  logic                       i_issue_en,
  input  logic [ADDR_W-1:0]          i_issue_addr,
  input  logic                       i_clr_req,
  output logic                       o_ready
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_ptr;
  logic [ADDR_W-1:0]   w_clr_ptr_nxt;
  logic [DEPTH-1:0]    r_busy;
  logic [DEPTH-1:0]    w_busy_nxt;
  logic                r_ready;
  logic                w_ready_nxt;

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_waddr;
  logic [DATA_W-1:0]   w_mem_wdata;

  logic                w_wr_ok;
  logic                w_iss_ok;
  logic [ADDR_W-1:0]   w_rd_addr [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] w_rd_data;
  logic [NUM_RD-1:0]   w_rd_busy;

  // Entry exists and is a real storage location (not the hard-wired zero).
  function automatic logic f_valid(input logic [ADDR_W-1:0] a);
    return (32'(a) < DEPTH) && !(ZERO_REG && (a == '0));
  endfunction

  // Writes and issues only land in RUN and are dropped by a same-cycle clear.
  assign w_wr_ok  = (r_state == ST_RUN) && !i_clr_req && i_wr_en    && f_valid(i_wr_addr);
  assign w_iss_ok = (r_state == ST_RUN) && !i_clr_req && i_issue_en && f_valid(i_issue_addr);

  // State, clear pointer, scoreboard and ready registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
      r_busy    <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
      r_busy    <= w_busy_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  // Next-state, clear engine, scoreboard update and array write selection.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    w_busy_nxt    = r_busy;
    w_ready_nxt   = r_ready;
    w_mem_we      = 1'b0;
    w_mem_waddr   = r_clr_ptr;
    w_mem_wdata   = '0;

    case (r_state)
      ST_CLEAR: begin
        w_busy_nxt    = '0;
        w_mem_we      = 1'b1;
        w_mem_waddr   = r_clr_ptr;
        w_mem_wdata   = '0;
        w_clr_ptr_nxt = r_clr_ptr + ADDR_W'(1);
        if (r_clr_ptr == LAST_ADDR) begin
          w_state_nxt   = ST_RUN;
          w_clr_ptr_nxt = '0;
          w_ready_nxt   = 1'b1;
        end
      end

      ST_RUN: begin
        if (i_clr_req) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_ptr_nxt = '0;
          w_busy_nxt    = '0;
          w_ready_nxt   = 1'b0;
        end else begin
          if (w_wr_ok) begin
            w_mem_we                = 1'b1;
            w_mem_waddr             = i_wr_addr;
            w_mem_wdata             = i_wr_data;
            w_busy_nxt[i_wr_addr]   = 1'b0;
          end
          // Applied after the write clear so a new producer supersedes.
          if (w_iss_ok) begin
            w_busy_nxt[i_issue_addr] = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  // Storage array; contents are initialised by the clear engine, not reset.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Unpack read addresses.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      w_rd_addr[i] = i_rd_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Combinational read ports with optional write forwarding.
  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if ((r_state == ST_RUN) && f_valid(w_rd_addr[i])) begin
        w_rd_data[i*DATA_W +: DATA_W] = r_mem[w_rd_addr[i]];
        w_rd_busy[i]                  = r_busy[w_rd_addr[i]];
`ifdef OTTER_RF_BYPASS_EN
        // The write completes the pending producer unless a new one issues now.
        if (w_wr_ok && (i_wr_addr == w_rd_addr[i])) begin
          w_rd_data[i*DATA_W +: DATA_W] = i_wr_data;
          if (!(w_iss_ok && (i_issue_addr == w_rd_addr[i]))) begin
            w_rd_busy[i] = 1'b0;
          end
        end
`else
        // No forwarding: the written value appears after the edge.
`endif
      end
    end
  end

  assign o_rd_data = w_rd_data;
  assign o_rd_busy = w_rd_busy;
  assign o_ready   = r_ready;

endmodule

// File: tb/tb_otter_param_reg_file.sv
// -----------------------------------------------------------------------------
// tb_otter_param_reg_file
//   Directed bench for otter_param_reg_file. Instance u_dut_a uses default
//   parameters (DEPTH=32, ZERO_REG=1); u_dut_b (DEPTH=24, ZERO_REG=0) shares
//   the stimulus to cover a writable r0 and out-of-range addresses.
// -----------------------------------------------------------------------------
module tb_otter_param_reg_file;

`ifdef OTTER_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic        clr_req;

  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_ready;
  logic [63:0] b_rd_data;
  logic [1:0]  b_rd_busy;
  logic        b_ready;

  int n_vec;
  int n_err;
  int lat;

  otter_param_reg_file u_dut_a (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (a_rd_data),
    .o_rd_busy    (a_rd_busy),
    .i_issue_en   (issue_en),
    .i_issue_addr (issue_addr),
    .i_clr_req    (clr_req),
    .o_ready      (a_ready)
  );

  otter_param_reg_file #(
    .DATA_W   (32),
    .DEPTH    (24),
    .NUM_RD   (2),
    .ZERO_REG (1'b0)
  ) u_dut_b (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (b_rd_data),
    .o_rd_busy    (b_rd_busy),
    .i_issue_en   (issue_en),
    .i_issue_addr (issue_addr),
    .i_clr_req    (clr_req),
    .o_ready      (b_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    issue_en = 1'b0;
    clr_req  = 1'b0;
  endtask

  task automatic rd(input logic [4:0] p0, input logic [4:0] p1);
    rd_addr = {p1, p0};
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic iss(input logic [4:0] a);
    issue_en   = 1'b1;
    issue_addr = a;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    issue_addr = '0;
    idle();
    rd(5'd0, 5'd1);

    // Reset state
    repeat (3) step();
    chk("rst_ready_a", 32'(a_ready), 32'd0);
    chk("rst_ready_b", 32'(b_ready), 32'd0);
    chk("rst_data_a", a_rd_data[31:0], 32'd0);
    chk("rst_busy_a", 32'(a_rd_busy), 32'd0);

    // Clear engine after release: A ready after 32 edges, B after 24
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      chk("rdy_lat_a", 32'(a_ready), 32'(k >= 32));
      chk("rdy_lat_b", 32'(b_ready), 32'(k >= 24));
    end

    // Every entry reads zero, nothing busy
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), 5'(31 - a));
      #1;
      chk("clr_data_a", a_rd_data[31:0] | a_rd_data[63:32], 32'd0);
      chk("clr_busy_a", 32'(a_rd_busy), 32'd0);
    end

    // Write r5, then r0
    wr(5'd5, 32'hDEAD_BEEF);
    rd(5'd5, 5'd0);
    #1;
    chk("wr_r5_same", a_rd_data[31:0], BYP ? 32'hDEAD_BEEF : 32'd0);
    step();
    wr(5'd0, 32'h0000_1234);
    #1;
    chk("rd_r5", a_rd_data[31:0], 32'hDEAD_BEEF);
    chk("x0_same_a", a_rd_data[63:32], 32'd0);
    chk("x0_same_b", b_rd_data[63:32], BYP ? 32'h0000_1234 : 32'd0);
    step();
    idle();
    #1;
    chk("x0_zero_a", a_rd_data[63:32], 32'd0);
    chk("x0_wr_b", b_rd_data[63:32], 32'h0000_1234);
    chk("rd_r5_b", b_rd_data[31:0], 32'hDEAD_BEEF);

    // Out of range for B (DEPTH=24), valid for A
    wr(5'd26, 32'h0000_0BAD);
    rd(5'd26, 5'd26);
    #1;
    chk("oor_same_b", b_rd_data[31:0], 32'd0);
    step();
    idle();
    iss(5'd26);
    #1;
    chk("oor_rd_a", a_rd_data[31:0], 32'h0000_0BAD);
    chk("oor_rd_b", b_rd_data[31:0], 32'd0);
    step();
    idle();
    #1;
    chk("oor_busy_a", 32'(a_rd_busy), 32'd3);
    chk("oor_busy_b", 32'(b_rd_busy), 32'd0);
    iss(5'd0);
    wr(5'd26, 32'h0000_0BAD);
    rd(5'd0, 5'd0);
    step();
    idle();
    #1;
    chk("x0_busy_a", 32'(a_rd_busy), 32'd0);
    chk("x0_busy_b", 32'(b_rd_busy), 32'd3);
    wr(5'd0, 32'h0000_1234);
    step();
    idle();

    // Scoreboard on r7
    iss(5'd7);
    step();
    idle();
    rd(5'd7, 5'd7);
    #1;
    chk("sb_busy", 32'(a_rd_busy), 32'd3);
    wr(5'd7, 32'h55);
    #1;
    chk("sb_wr_busy", 32'(a_rd_busy), BYP ? 32'd0 : 32'd3);
    chk("sb_wr_data", a_rd_data[63:32], BYP ? 32'h55 : 32'd0);
    step();
    idle();
    #1;
    chk("sb_clr_busy", 32'(a_rd_busy), 32'd0);
    chk("sb_clr_data", a_rd_data[63:32], 32'h55);
    wr(5'd7, 32'h66);
    iss(5'd7);
    #1;
    chk("sb_both_busy", 32'(a_rd_busy), 32'd0);
    chk("sb_both_data", a_rd_data[31:0], BYP ? 32'h66 : 32'h55);
    step();
    idle();
    #1;
    chk("sb_set_wins", 32'(a_rd_busy), 32'd3);
    chk("sb_set_data", a_rd_data[31:0], 32'h66);

    // Bypass behaviour on r3
    iss(5'd3);
    step();
    idle();
    wr(5'd3, 32'hA5A5_A5A5);
    rd(5'd3, 5'd3);
    #1;
    chk("byp_data", a_rd_data[31:0], BYP ? 32'hA5A5_A5A5 : 32'd0);
    chk("byp_busy", 32'(a_rd_busy), BYP ? 32'd0 : 32'd3);
    step();
    idle();
    #1;
    chk("byp_after_data", a_rd_data[31:0], 32'hA5A5_A5A5);
    chk("byp_after_busy", 32'(a_rd_busy), 32'd0);
    iss(5'd3);
    step();
    wr(5'd3, 32'h11);
    #1;
    chk("byp_iss_busy", 32'(a_rd_busy), 32'd3);
    chk("byp_iss_data", a_rd_data[31:0], BYP ? 32'h11 : 32'hA5A5_A5A5);
    step();
    idle();
    #1;
    chk("byp_iss_after", 32'(a_rd_busy), 32'd3);
    wr(5'd3, 32'h12);
    step();
    idle();

    // Mid-operation clear with a dropped write and issue
    wr(5'd9, 32'h77);
    step();
    idle();
    iss(5'd4);
    step();
    idle();
    rd(5'd9, 5'd4);
    #1;
    chk("mc_pre_r9", a_rd_data[31:0], 32'h77);
    chk("mc_pre_busy", 32'(a_rd_busy), 32'd2);
    clr_req = 1'b1;
    wr(5'd10, 32'h99);
    iss(5'd11);
    step();
    idle();
    rd(5'd9, 5'd10);
    #1;
    chk("mc_ready_a", 32'(a_ready), 32'd0);
    chk("mc_ready_b", 32'(b_ready), 32'd0);
    chk("mc_clr_data", a_rd_data[31:0], 32'd0);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        wr(5'd1, 32'hF00);
        iss(5'd12);
      end else begin
        idle();
      end
      step();
      if (a_ready) begin
        lat = k;
        break;
      end
    end
    idle();
    chk("mc_latency", 32'(lat), 32'd32);
    rd(5'd9, 5'd10);
    #1;
    chk("mc_r9_r10", a_rd_data[31:0] | a_rd_data[63:32], 32'd0);
    rd(5'd4, 5'd11);
    #1;
    chk("mc_busy_4_11", 32'(a_rd_busy), 32'd0);
    rd(5'd1, 5'd12);
    #1;
    chk("mc_ign_wr", a_rd_data[31:0], 32'd0);
    chk("mc_ign_iss", 32'(a_rd_busy), 32'd0);
    chk("mc_ready_b2", 32'(b_ready), 32'd1);

    // Async reset in the middle of a clear sequence
    wr(5'd20, 32'hABC);
    step();
    idle();
    clr_req = 1'b1;
    step();
    idle();
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    chk("ar_ready", 32'(a_ready), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (a_ready) begin
        lat = k;
        break;
      end
    end
    chk("ar_latency", 32'(lat), 32'd32);
    rd(5'd20, 5'd20);
    #1;
    chk("ar_r20", a_rd_data[31:0], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/otter_param_reg_file.md
Name: otter_param_reg_file

Overview:
- Parametrised successor to the OTTER register file.
- Configurable data width, depth and read-port count.
- Adds an in-file hazard scoreboard (busy bits) and a sequential clear engine that zeroes the array after reset or on request.
- Sits between decode (read ports, issue marking) and writeback (write port) in the pipelined OTTER.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers (2..256).
- NUM_RD, 2, number of asynchronous read ports (1..4).
- ZERO_REG, 1, when 1, entry 0 is hard-wired zero: never written, never busy.
- ADDR_W, $clog2(DEPTH), derived; not overridden.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- WR_EN  in  1  writeback write enable.
- WR_ADDR  in  ADDR_W  write address.
- WR_DATA  in  DATA_W  write data.
- RD_ADDR  in  NUM_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W].
- RD_DATA  out  NUM_RD*DATA_W  packed read data.
- RD_BUSY  out  NUM_RD  per-port: addressed register has a pending producer.
- ISSUE_EN  in  1  mark ISSUE_ADDR busy (instruction issued with that destination).
- ISSUE_ADDR  in  ADDR_W  destination being issued.
- CLR_REQ  in  1  request full clear of array and scoreboard.
- READY  out  1  high when the file accepts traffic.

Behaviour:
- FSM states: CLEAR, RUN.
- RST_N low (async):
  - state=CLEAR, clr_ptr=0, all busy bits=0, READY=0.
  - Array contents are not reset directly; the clear engine zeroes them.
- CLEAR:
  - Each clock writes 0 to entry clr_ptr, then clr_ptr++.
  - On the edge that clears entry DEPTH-1, go to RUN; READY=1 the following cycle.
  - First READY=1 is therefore exactly DEPTH clocks after RST_N deasserts.
  - WR_EN, ISSUE_EN and CLR_REQ are ignored; RD_DATA=0, RD_BUSY=0.
- RUN:
  - CLR_REQ=1 at an edge: state=CLEAR, clr_ptr=0, all busy bits cleared, READY=0 next cycle.
  - A write or issue presented in that same cycle is dropped.
- Write: synchronous. With WR_EN=1 in RUN, mem[WR_ADDR]<=WR_DATA, except when ZERO_REG=1 and WR_ADDR=0, or WR_ADDR>=DEPTH (dropped).
- Read: combinational.
  - RD_DATA_i = mem[RD_ADDR_i].
  - Reads 0 when ZERO_REG=1 and the address is 0, or when the address is >=DEPTH.
- Scoreboard, per-entry busy bit:
  - ISSUE_EN sets busy[ISSUE_ADDR]; WR_EN clears busy[WR_ADDR]; both take effect at the edge.
  - Same address, same cycle: set wins (the new producer supersedes).
  - Entry 0 (ZERO_REG=1) and out-of-range addresses are never set.
- RD_BUSY_i = busy[RD_ADDR_i], subject to the bypass masking below.
- Multiple read ports may address the same entry; each port is independent.

Optional Feature:
- Macro: OTTER_RF_BYPASS_EN.
- Defined:
  - Write-to-read forwarding. If WR_EN=1, state RUN, the write is legal and WR_ADDR==RD_ADDR_i, then RD_DATA_i=WR_DATA in the same cycle.
  - RD_BUSY_i is forced 0 for that port in that cycle, unless ISSUE_EN targets the same address that cycle; RD_BUSY stays combinational from the current busy bits.
- Undefined:
  - No forwarding. RD_DATA_i shows the old value until the edge after the write.
  - RD_BUSY_i reflects busy[] unmasked.

Test Plan:
- Reset clear: RST_N low for 3 cycles then high, DEPTH=32 -> READY=0 for 32 clocks and 1 on the 33rd. Every RD_ADDR then reads 0 and RD_BUSY=0.
- Write/read and x0: write 0xDEADBEEF to r5, then 0x1234 to r0 -> r5 reads 0xDEADBEEF next cycle; r0 reads 0. With ZERO_REG=0, r0 reads 0x1234.
- Scoreboard: ISSUE r7, next cycle port1 reads r7 -> RD_BUSY[1]=1. Write 0x55 to r7 -> busy clears after the edge. Simultaneous ISSUE r7 and WR r7 -> r7 remains busy.
- Bypass (macro defined): r3 busy, WR_EN r3=0xA5A5A5A5, port0 reads r3 in the same cycle -> RD_DATA0=0xA5A5A5A5, RD_BUSY[0]=0. Macro undefined -> old value, RD_BUSY[0]=1.
- Mid-op clear: r9=0x77, r4 busy, assert CLR_REQ together with WR r10 -> READY drops, the r10 write is dropped, r9/r10 read 0 and all busy bits are 0 once READY returns DEPTH cycles later.
- Async reset mid-clear: assert RST_N low during CLEAR at clr_ptr=10 -> READY stays 0, clear restarts from 0, full DEPTH-cycle count from release.
